// File: rtl/blink_pulse_gen_pkg.sv
// rtl/blink_pulse_gen_pkg.sv - shared state encoding and timer sizing for blink_pulse_gen
package blink_pulse_gen_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ON   = 2'd1;
   localparam logic [1:0] ST_OFF  = 2'd2;

   // Timer only ever holds phase_length-1, so clog2 of the longer phase is enough.
   function automatic int timer_w(input int on_cycles, input int off_cycles);
      int longest;
      longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
      return ($clog2(longest) < 1) ? 1 : $clog2(longest);
   endfunction

endpackage

// File: rtl/blink_pulse_gen_sat_counter.sv
// rtl/blink_pulse_gen_sat_counter.sv - saturating up/down pending-event counter
// drop strobes when an increment hits a full counter with no offsetting decrement.
module sat_counter
   import blink_pulse_gen_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         drop
);

   localparam logic [W-1:0] MAX = '1;

   assign drop = inc & ~dec & (count == MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && !dec && count != MAX) begin
         count <= count + W'(1);
      end else if (dec && !inc && count != '0) begin
         count <= count - W'(1);
      end
   end

endmodule

// File: rtl/blink_pulse_gen.sv
// rtl/blink_pulse_gen.sv - turns one-cycle event strobes into ON/OFF blinks, queueing overlaps
// one blink per event; events during a blink wait in a saturating counter.
module blink_pulse_gen
   import blink_pulse_gen_pkg::*;
#(
   parameter int ON_CYCLES  = 2,
   parameter int OFF_CYCLES = 2,
   parameter int CNT_W      = 4
) (
   input  logic             clk_4Hz,
   input  logic             rst,
   input  logic             event_in,
   input  logic             clr_overflow,
   output logic             blink_out,
   output logic             busy,
   output logic [CNT_W-1:0] pending,
   output logic             overflow
);

   localparam int TW = timer_w(ON_CYCLES, OFF_CYCLES);
   localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

   logic [1:0]    state;
   logic [TW-1:0] timer;
   logic          has_pending;
   logic          launch;
   logic          cnt_inc;
   logic          cnt_dec;
   logic          drop;

   assign has_pending = (pending != '0);
   assign launch = (event_in | has_pending) &
                   ((state == ST_IDLE) | ((state == ST_OFF) & (timer == '0)));

   // A launch with an empty queue consumes event_in directly instead of counting it.
   assign cnt_dec = launch & has_pending;
   assign cnt_inc = event_in & ~(launch & ~has_pending);

   sat_counter #(.W(CNT_W)) u_pending (
      .clk   (clk_4Hz),
      .rst   (rst),
      .inc   (cnt_inc),
      .dec   (cnt_dec),
      .count (pending),
      .drop  (drop)
   );

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk_4Hz) begin
      if (rst) begin
         state     <= ST_IDLE;
         timer     <= '0;
         blink_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end

         if (launch) begin
            state     <= ST_ON;
            timer     <= ON_LOAD;
            blink_out <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: ;
               ST_ON: begin
                  if (timer != '0) begin
                     timer <= timer - TW'(1);
                  end else begin
                     state     <= ST_OFF;
                     timer     <= OFF_LOAD;
                     blink_out <= 1'b0;
                  end
               end
               ST_OFF: begin
                  if (timer != '0) begin
                     timer <= timer - TW'(1);
                  end else begin
                     state <= ST_IDLE;
                  end
               end
               default: begin
                  state     <= ST_IDLE;
                  blink_out <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_blink_pulse_gen.sv
// tb/tb_blink_pulse_gen.sv - scoreboard bench for blink_pulse_gen (2/2 and 1/1 configurations)
module tb_blink_pulse_gen;

   logic       clk = 1'b0;
   logic       rst_a = 1'b0, ev_a = 1'b0, clr_a = 1'b0;
   logic       rst_b = 1'b0, ev_b = 1'b0, clr_b = 1'b0;
   logic       blink_a, busy_a, ovf_a, blink_b, busy_b, ovf_b;
   logic [3:0] pend_a, pend_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         sel;
      logic       blink;
      logic       busy;
      logic [3:0] pend;
      logic       ovf;
      string      nm;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   blink_pulse_gen #(.ON_CYCLES(2), .OFF_CYCLES(2), .CNT_W(4)) dut_a (
      .clk_4Hz(clk), .rst(rst_a), .event_in(ev_a), .clr_overflow(clr_a),
      .blink_out(blink_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a)
   );

   blink_pulse_gen #(.ON_CYCLES(1), .OFF_CYCLES(1), .CNT_W(4)) dut_b (
      .clk_4Hz(clk), .rst(rst_b), .event_in(ev_b), .clr_overflow(clr_b),
      .blink_out(blink_b), .busy(busy_b), .pending(pend_b), .overflow(ovf_b)
   );

   task automatic chk(input string nm, input string fld, input logic [3:0] act, input logic [3:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s %s: got %0h expected %0h", nm, fld, act, expv);
      end
   endtask

   // Monitor: every edge that has a queued expectation is checked 1 time unit later.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (!e.sel) begin
            chk(e.nm, "blink_out", {3'b0, blink_a}, {3'b0, e.blink});
            chk(e.nm, "busy",      {3'b0, busy_a},  {3'b0, e.busy});
            chk(e.nm, "pending",   pend_a,          e.pend);
            chk(e.nm, "overflow",  {3'b0, ovf_a},   {3'b0, e.ovf});
         end else begin
            chk(e.nm, "blink_out", {3'b0, blink_b}, {3'b0, e.blink});
            chk(e.nm, "busy",      {3'b0, busy_b},  {3'b0, e.busy});
            chk(e.nm, "pending",   pend_b,          e.pend);
            chk(e.nm, "overflow",  {3'b0, ovf_b},   {3'b0, e.ovf});
         end
      end
   end

   task automatic step(input bit sel, input logic r, input logic ev, input logic clr,
                       input logic eb, input logic ebusy, input logic [3:0] ep,
                       input logic eo, input string nm);
      exp_t e;
      rst_a = sel ? 1'b0 : r;  ev_a = sel ? 1'b0 : ev;  clr_a = sel ? 1'b0 : clr;
      rst_b = sel ? r : 1'b0;  ev_b = sel ? ev : 1'b0;  clr_b = sel ? clr : 1'b0;
      e.sel = sel; e.blink = eb; e.busy = ebusy; e.pend = ep; e.ovf = eo; e.nm = nm;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input bit sel, input string nm);
      step(sel, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, nm);
   endtask

   // Pending count with event_in held high from edge 0 (ON=2/OFF=2): +3 per 4-edge period until 15.
   function automatic logic [3:0] held_pend(input int n);
      if (n < 20) return 4'(3 * (n / 4) + (n % 4));
      return 4'd15;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      #2;

      do_reset(0, "single_rst");
      for (int n = 0; n <= 5; n++)
         step(0, 0, n == 0, 0, n < 2, n < 4, 4'd0, 0, $sformatf("single[%0d]", n));

      do_reset(0, "triple_rst");
      for (int n = 0; n <= 13; n++) begin
         logic [3:0] p;
         p = (n == 0) ? 4'd0 : (n == 1) ? 4'd1 : (n <= 3) ? 4'd2 : (n <= 7) ? 4'd1 : 4'd0;
         step(0, 0, n < 3, 0, (n < 12) && (n % 4 < 2), n < 12, p, 0, $sformatf("triple[%0d]", n));
      end

      do_reset(0, "held_rst");
      for (int n = 0; n <= 85; n++) begin
         logic [3:0] p;
         if (n < 20)       p = held_pend(n);
         else if (n >= 80) p = 4'd0;
         else              p = 4'(15 - (n / 4 - 5));
         step(0, 0, n <= 23, 0, (n < 84) && (n % 4 < 2), n < 84, p, n >= 21, $sformatf("held[%0d]", n));
      end

      do_reset(0, "midon_pre_rst");
      for (int n = 0; n <= 4; n++)
         step(0, 0, 1, 0, (n % 4 < 2), 1, (n < 4) ? 4'(n) : 4'd3, 0, $sformatf("midon[%0d]", n));
      step(0, 1, 0, 0, 0, 0, 4'd0, 0, "midon_rst");
      for (int n = 0; n <= 4; n++)
         step(0, 0, n == 0, 0, n < 2, n < 4, 4'd0, 0, $sformatf("midon_after[%0d]", n));

      do_reset(0, "ovfclr_rst");
      for (int n = 0; n <= 23; n++)
         step(0, 0, n <= 22, n >= 22, n % 4 < 2, 1, held_pend(n), (n == 21) || (n == 22),
              $sformatf("ovfclr[%0d]", n));

      do_reset(1, "fast_rst");
      for (int n = 0; n <= 20; n++)
         step(1, 0, 1, 0, n % 2 == 0, 1, 4'((n + 1) / 2), 0, $sformatf("fast[%0d]", n));
      ev_b = 1'b0;

      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
